// File: rtl/quantizer.sv
// quantizer: JPEG quantizer stage (reciprocal table x coef, floor or QUANTIZER_ROUND_EN round-half-away, saturate to out_width; ports clk/reset, in_valid/in_first/in_coef, tbl_we/tbl_addr/tbl_data, out_valid/out_coef/out_index/out_last)
module pipelined_multiplier #(
  parameter int width = 16,
  parameter int depth = 2
) (
  input  logic                      clk,
  input  logic signed [width-1:0]   a,
  input  logic signed [width-1:0]   b,
  output logic signed [2*width-1:0] p
);
  logic signed [2*width-1:0] pipe [depth];
  always_ff @(posedge clk) begin
    pipe[0] <= (2*width)'(a) * (2*width)'(b);
    for (int i = 1; i < depth; i++) pipe[i] <= pipe[i-1];
  end
  assign p = pipe[depth-1];
endmodule

module quantizer #(
  parameter int width      = 16,
  parameter int mult_depth = 2,
  parameter int frac_bits  = 14,
  parameter int out_width  = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic                        in_first,
  input  logic signed [width-1:0]     in_coef,
  input  logic                        tbl_we,
  input  logic [5:0]                  tbl_addr,
  input  logic signed [width-1:0]     tbl_data,
  output logic                        out_valid,
  output logic signed [out_width-1:0] out_coef,
  output logic [5:0]                  out_index,
  output logic                        out_last
);
  localparam int pw = 2*width + 1;
  localparam logic signed [pw-1:0] hi = pw'((1 << (out_width-1)) - 1);
  localparam logic signed [pw-1:0] lo = ~hi;
  logic [5:0] cnt, idx, s0_idx;
  logic signed [width-1:0] tbl [64];
  logic signed [width-1:0] s0_coef, s0_rec;
  logic s0_v;
  logic [mult_depth-1:0] vp;
  logic [5:0] ip [mult_depth];
  logic signed [2*width-1:0] p;
  logic signed [pw-1:0] pe, sc;
  logic signed [out_width-1:0] sat;
`ifdef QUANTIZER_ROUND_EN
  localparam logic signed [pw-1:0] half = pw'(1) << (frac_bits-1);
  logic signed [pw-1:0] mag, rnd;
`endif
  assign idx = in_first ? 6'd0 : cnt;
  always_ff @(posedge clk) begin
    if (tbl_we) tbl[tbl_addr] <= tbl_data;
    s0_coef <= in_coef;
    s0_rec  <= tbl[idx];
    s0_idx  <= idx;
    ip[0]   <= s0_idx;
    for (int i = 1; i < mult_depth; i++) ip[i] <= ip[i-1];
  end
  pipelined_multiplier #(.width(width), .depth(mult_depth)) u_mult (
    .clk(clk),
    .a(s0_coef),
    .b(s0_rec),
    .p(p)
  );
  always_comb begin
    pe = pw'(p);
`ifdef QUANTIZER_ROUND_EN
    mag = pe[pw-1] ? -pe : pe;
    rnd = (mag + half) >>> frac_bits;
    sc  = pe[pw-1] ? -rnd : rnd;
`else
    sc  = pe >>> frac_bits;
`endif
    sat = sc > hi ? hi[out_width-1:0] : sc < lo ? lo[out_width-1:0] : sc[out_width-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 6'd0;
      s0_v      <= 1'b0;
      vp        <= '0;
      out_valid <= 1'b0;
      out_coef  <= '0;
      out_index <= 6'd0;
      out_last  <= 1'b0;
    end else begin
      if (in_valid) cnt <= idx + 6'd1;
      s0_v  <= in_valid;
      vp[0] <= s0_v;
      for (int i = 1; i < mult_depth; i++) vp[i] <= vp[i-1];
      out_valid <= vp[mult_depth-1];
      out_coef  <= sat;
      out_index <= ip[mult_depth-1];
      out_last  <= vp[mult_depth-1] && ip[mult_depth-1] == 6'd63;
    end
  end
endmodule

// File: tb/tb_quantizer.sv
// tb_quantizer: randomized and directed checks of quantizer against a behavioural model
module tb_quantizer;
  logic clk = 0, reset = 1, in_valid = 0, in_first = 0, tbl_we = 0;
  logic signed [15:0] in_coef = 0, tbl_data = 0;
  logic [5:0] tbl_addr = 0;
  logic out_valid, out_last;
  logic signed [11:0] out_coef;
  logic [5:0] out_index;
  int checks = 0, errors = 0;
  int cyc = 0, mcnt = 0;
  bit started = 0;
  int tbl_m [64];
  typedef struct {int due; int c; int i;} exp_t;
  typedef struct {int c; int i; bit l;} obs_t;
  exp_t eq[$];
  obs_t obs[$];

  quantizer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first), .in_coef(in_coef),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .out_valid(out_valid), .out_coef(out_coef), .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic int qm(int coef, int rec);
    longint p = longint'(coef) * longint'(rec);
    longint d = 64'sd16384;
    longint r;
`ifdef QUANTIZER_ROUND_EN
    r = p >= 0 ? (p + d/2) / d : -((-p + d/2) / d);
`else
    r = p >= 0 ? p / d : -((-p + d - 1) / d);
`endif
    if (r > 2047) r = 2047;
    if (r < -2048) r = -2048;
    return int'(r);
  endfunction

  task automatic chk(string n, int a, int e);
    checks++;
    if (a !== e) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask

  always @(posedge clk) begin
    int idx;
    cyc++;
    started = 1;
    if (reset) begin
      eq.delete();
      mcnt = 0;
    end else if (in_valid) begin
      idx = in_first ? 0 : mcnt;
      eq.push_back('{cyc + 3, qm(int'(in_coef), tbl_m[idx]), idx});
      mcnt = (idx + 1) % 64;
    end
    if (tbl_we) tbl_m[tbl_addr] = int'(tbl_data);
  end

  always @(negedge clk) begin
    bit ev;
    if (started) begin
      ev = eq.size() > 0 && eq[0].due == cyc;
      chk("out_valid", int'(out_valid), int'(ev));
      if (ev) begin
        chk("out_coef", int'(out_coef), eq[0].c);
        chk("out_index", int'(out_index), eq[0].i);
        chk("out_last", int'(out_last), int'(eq[0].i == 63));
        void'(eq.pop_front());
      end else chk("out_last_idle", int'(out_last), 0);
      if (out_valid) obs.push_back('{int'(out_coef), int'(out_index), out_last});
    end
  end

  task automatic step(bit v, bit f, int c, bit we = 0, int a = 0, int d = 0);
    in_valid = v; in_first = f; in_coef = 16'(c);
    tbl_we = we; tbl_addr = 6'(a); tbl_data = 16'(d);
    @(posedge clk); #1;
    in_valid = 0; in_first = 0; tbl_we = 0;
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0);
  endtask

  task automatic chk_obs(string n, int k, int c, int i);
    if (obs.size() > k) begin
      chk({n, "_coef"}, obs[k].c, c);
      chk({n, "_idx"}, obs[k].i, i);
    end else chk({n, "_missing"}, obs.size(), k + 1);
  endtask

  initial begin
    reset = 1;
    idle(3);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_coef", int'(out_coef), 0);
    chk("rst_index", int'(out_index), 0);
    chk("rst_last", int'(out_last), 0);
    reset = 0;
    for (int a = 0; a < 64; a++) step(0, 0, 0, 1, a, 16384);
    idle(2);

    obs.delete();
    step(1, 1, 100); step(1, 0, -100); step(1, 0, 0);
    idle(6);
    chk("q1_count", obs.size(), 3);
    chk_obs("q1_a", 0, 100, 0);
    chk_obs("q1_b", 1, -100, 1);
    chk_obs("q1_c", 2, 0, 2);

    for (int a = 0; a < 3; a++) step(0, 0, 0, 1, a, 1024);
    obs.delete();
    step(1, 1, 100); step(1, 0, -100); step(1, 0, 24);
    idle(6);
    chk_obs("q16_pos", 0, 6, 0);
`ifdef QUANTIZER_ROUND_EN
    chk_obs("q16_neg", 1, -6, 1);
    chk_obs("q16_half", 2, 2, 2);
`else
    chk_obs("q16_neg", 1, -7, 1);
    chk_obs("q16_half", 2, 1, 2);
`endif

    step(0, 0, 0, 1, 0, 16384); step(0, 0, 0, 1, 1, 16384);
    obs.delete();
    step(1, 1, 32767); step(1, 0, -32768);
    idle(6);
    chk_obs("sat_hi", 0, 2047, 0);
    chk_obs("sat_lo", 1, -2048, 1);

    obs.delete();
    step(1, 1, 7); step(1, 0, 7); step(1, 0, 7);
    step(1, 0, 40, 1, 3, 2048);
    step(1, 1, 0); step(1, 0, 0); step(1, 0, 0); step(1, 0, 40);
    idle(6);
    chk_obs("wr_old", 3, 40, 3);
    chk_obs("wr_new", 7, 5, 3);

    for (int a = 0; a < 64; a++) step(0, 0, 0, 1, a, $urandom_range(0, 32767));
    obs.delete();
    for (int k = 0; k < 134; k++) step(1, k == 0 || k == 133, int'(16'($urandom)));
    idle(6);
    chk("wrap_count", obs.size(), 134);
    if (obs.size() >= 134) begin
      chk("wrap_last64", int'(obs[63].l), 1);
      chk("wrap_idx64", obs[63].i, 63);
      chk("wrap_last63", int'(obs[62].l), 0);
      chk("wrap_idx65", obs[64].i, 0);
      chk("wrap_last128", int'(obs[127].l), 1);
      chk("wrap_idx129", obs[128].i, 0);
      chk("wrap_idx133", obs[132].i, 4);
      chk("first_mid", obs[133].i, 0);
    end

    obs.delete();
    step(1, 0, 11); step(1, 0, 22); step(1, 0, 33);
    reset = 1;
    idle(2);
    reset = 0;
    idle(6);
    chk("rst_flush", obs.size(), 0);
    step(1, 0, 50);
    idle(6);
    chk("rst_count", obs.size(), 1);
    chk_obs("rst_next", 0, qm(50, tbl_m[0]), 0);

    for (int k = 0; k < 3000; k++) begin
      reset = $urandom_range(0, 199) == 0;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 7) == 0 ? ($urandom_range(0, 1) ? 32767 : -32768) : int'(16'($urandom)),
           $urandom_range(0, 19) == 0, $urandom_range(0, 63), $urandom_range(0, 32767));
    end
    reset = 0;
    idle(8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
